motor_step_gen: RTL and testbench
=================================

# motor_step_gen

Step/direction pulse generator for the stepper driver, directly downstream of the IR direction detector. It consumes the detector's `dir`/`en` pair and produces a `step` pulse train with a linear acceleration ramp, a direction output held stable around every step, and a signed position count. Direction reversals always pass through a full deceleration to standstill, so the driver never sees a direction change at speed.

## Interface
- `PERIOD_MAX`, 40: start/stop step period in clocks. Speed ramps from and to this value.
- `PERIOD_MIN`, 10: cruise step period in clocks.
- `ACC_STEP`, 10: period change per step while ramping.
- `PULSE_W`, 4: `step` high time in clocks. Must satisfy PULSE_W < PERIOD_MIN.
- `DIR_SETUP`, 3: clocks from `mdir` update to the first `step` rise. Must be ≥ 1.
- `PW`, 16: position counter width.

Ports:
- `CLK` in 1: system clock. One clock only.
- `RST` in 1: reset, synchronous, active-high.
- `en` in 1: run request from the direction detector. Synchronous to `CLK`.
- `dir` in 1: requested direction. 1 = forward, 0 = reverse. Synchronous to `CLK`.
- `step` out 1: step pulse to the driver.
- `mdir` out 1: direction to the driver.
- `busy` out 1: high while not IDLE.
- `pos` out PW: signed position. Incremented or decremented once per step.

## Operation
- Reset values: state IDLE, `step`=0, `mdir`=0, `busy`=0, `pos`=0, current period `cur`=PERIOD_MAX, phase counter `ph`=0.
- All outputs are registered.

States:
- **IDLE**
  - `busy`=0 and `step`=0.
  - If `en`=1 at a clock edge: `mdir`←`dir`, `cur`←PERIOD_MAX, go to SETUP.
- **SETUP**
  - Hold `mdir`.
  - Count DIR_SETUP clocks, then go to RUN with `ph`=0.
- **RUN**
  - `ph` counts 0..`cur`-1. `step`=1 while `ph`<PULSE_W.
  - On the edge where `step` rises, `pos` changes by +1 if `mdir`=1, else −1. The update is visible in the same cycle as `step`=1.
  - At `ph`=`cur`-1 (period wrap):
    - If `en`=1 and `dir`=`mdir`: `cur`←max(`cur`-ACC_STEP, PERIOD_MIN), stay in RUN.
    - Otherwise: `cur`←`cur`+ACC_STEP. If the new value is ≥ PERIOD_MAX, go to IDLE. Otherwise go to DECEL.
- **DECEL**
  - Same pulse and position behaviour as RUN.
  - At period wrap:
    - If `en`=1 and `dir`=`mdir`: `cur`←max(`cur`-ACC_STEP, PERIOD_MIN), go to RUN. This is a resume from current speed.
    - Otherwise: `cur`←`cur`+ACC_STEP. If ≥ PERIOD_MAX, go to IDLE.
- `en` and `dir` are sampled only in IDLE and at period wraps. Changes mid-period never truncate a pulse or a period.
- A reversal request (`dir`≠`mdir` with `en`=1) decelerates to IDLE. IDLE then re-enters SETUP with the new `mdir`.
- `pos` wraps modulo 2^PW. No saturation.
- `RST` mid-operation: all state returns to reset values on that edge, including forcing `step` to 0 mid-pulse.

## Timing
- Latency from start request:
  - `en` sampled high at edge t → `busy`=1 and `mdir` valid from t.
  - First `step`=1 at edge t+DIR_SETUP.
- Step period sequence with defaults: 40, 30, 20, 10, 10, … Rising-edge spacing equals `cur` exactly.
- Each pulse is exactly PULSE_W clocks.
- `mdir` changes only in IDLE→SETUP, so it is stable ≥ DIR_SETUP clocks before the first step and throughout the motion.
- Stop with defaults from cruise: after the wrap that samples `en`=0, two more steps follow at periods 20 and 30. The next wrap returns to IDLE, and `busy` falls on that edge.
- A single-step move is possible: if `en` drops during the first period, the wrap sees 40+10 ≥ 40 and goes to IDLE after one step.

## Test plan
- **Reset then start:** hold `RST` 2 clocks, then `en`=1, `dir`=1 → outputs at reset values during reset. `mdir`=1 and `busy`=1 on the first sampled edge. First `step` 3 clocks later. Rising-edge spacings 40, 30, 20, 10, 10. Each pulse 4 clocks. `pos` counts 1, 2, 3, ….
- **Stop from cruise:** at cruise, drop `en` → after the current period, steps follow at spacings 20 and 30, then `busy`=0. Total `pos` matches the number of pulses seen.
- **Reversal:** at cruise, set `dir`=0 with `en`=1 → decel steps 20, 30, then IDLE for 1 clock, new SETUP with `mdir`=0, DIR_SETUP gap, then `pos` decrements. `mdir` never toggles while `step`=1 or within 3 clocks before a rise.
- **Resume during decel:** drop `en` at cruise, then restore `en` (same `dir`) after the first decel step → spacings 20, then 10, 10, …; never reaches IDLE.
- **Single step:** pulse `en` for 1 clock → exactly one `step` pulse, `pos`=±1, `busy` high for 3+40 clocks.
- **Wrap and mid-run reset:** preload near 2^15−1 by running forward → `pos` wraps 0x7FFF→0x8000. Assert `RST` while `step`=1 → `step`=0 and `pos`=0 on the next edge.

Source files
------------

// File: rtl/motor_step_gen.sv
// Step/direction pulse generator with a linear acceleration ramp and signed position count.
// Direction only changes from standstill; every reversal decelerates to IDLE first.
module motor_step_gen #(
    parameter int PERIOD_MAX = 40,
    parameter int PERIOD_MIN = 10,
    parameter int ACC_STEP   = 10,
    parameter int PULSE_W    = 4,
    parameter int DIR_SETUP  = 3,
    parameter int PW         = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          en,
    input  logic          dir,
    output logic          step,
    output logic          mdir,
    output logic          busy,
    output logic [PW-1:0] pos
);

    // Counter must hold both the longest decelerated period and the setup delay.
    localparam int CNT_MAX = (PERIOD_MAX + ACC_STEP > DIR_SETUP) ? PERIOD_MAX + ACC_STEP : DIR_SETUP;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] P_MAX   = CW'(PERIOD_MAX);
    localparam logic [CW-1:0] P_MIN   = CW'(PERIOD_MIN);
    localparam logic [CW-1:0] A_STEP  = CW'(ACC_STEP);
    localparam logic [CW-1:0] P_W     = CW'(PULSE_W);
    localparam logic [CW-1:0] DS_LAST = CW'(DIR_SETUP - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        RUN,
        DECEL
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cur, cur_n;
    logic [CW-1:0] ph, ph_n;
    logic          step_n, mdir_n, busy_n;
    logic [PW-1:0] pos_n;

    logic [CW-1:0] ph_inc, cur_up, cur_dn;
    logic [PW-1:0] pos_step;
    logic          keep_going;

    assign ph_inc     = ph + 1'b1;
    assign cur_up     = cur + A_STEP;
    assign cur_dn     = (cur >= P_MIN + A_STEP) ? cur - A_STEP : P_MIN;
    assign pos_step   = mdir ? pos + 1'b1 : pos - 1'b1;
    assign keep_going = en && (dir == mdir);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_n = state;
        cur_n   = cur;
        ph_n    = ph;
        step_n  = 1'b0;
        mdir_n  = mdir;
        pos_n   = pos;

        case (state)
            IDLE: begin
                ph_n = '0;
                if (en) begin
                    mdir_n  = dir;
                    cur_n   = P_MAX;
                    state_n = SETUP;
                end
            end

            SETUP: begin
                if (ph == DS_LAST) begin
                    ph_n    = '0;
                    state_n = RUN;
                    step_n  = 1'b1;
                    pos_n   = pos_step;
                end else begin
                    ph_n = ph_inc;
                end
            end

            // RUN and DECEL differ only in name: both sample en/dir at the period wrap.
            RUN, DECEL: begin
                if (ph == cur - 1'b1) begin
                    ph_n = '0;
                    if (keep_going) begin
                        cur_n   = cur_dn;
                        state_n = RUN;
                        step_n  = 1'b1;
                        pos_n   = pos_step;
                    end else begin
                        cur_n = cur_up;
                        if (cur_up >= P_MAX) begin
                            state_n = IDLE;
                        end else begin
                            state_n = DECEL;
                            step_n  = 1'b1;
                            pos_n   = pos_step;
                        end
                    end
                end else begin
                    ph_n   = ph_inc;
                    step_n = (ph_inc < P_W);
                end
            end

            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments keep every register updating from the same pre-edge values.
        if (RST) begin
            state <= IDLE;
            cur   <= P_MAX;
            ph    <= '0;
            step  <= 1'b0;
            mdir  <= 1'b0;
            busy  <= 1'b0;
            pos   <= '0;
        end else begin
            state <= state_n;
            cur   <= cur_n;
            ph    <= ph_n;
            step  <= step_n;
            mdir  <= mdir_n;
            busy  <= busy_n;
            pos   <= pos_n;
        end
    end

endmodule

// File: tb/tb_motor_step_gen.sv
// Self-checking bench for motor_step_gen: a move-level procedural model predicts every output
// each cycle, while directed and random stimulus exercise ramps, stops, reversals and wraps.
`timescale 1ns/1ps
module tb_motor_step_gen;

    localparam int PERIOD_MAX = 40;
    localparam int PERIOD_MIN = 10;
    localparam int ACC_STEP   = 10;
    localparam int PULSE_W    = 4;
    localparam int DIR_SETUP  = 3;
    localparam int PW         = 16;

    logic          CLK = 1'b0;
    logic          RST, en, dir;
    logic          step, mdir, busy;
    logic [PW-1:0] pos;
    logic          step8, mdir8, busy8;
    logic [7:0]    pos8;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic          e_step = 1'b0, e_mdir = 1'b0, e_busy = 1'b0;
    logic [PW-1:0] e_pos  = '0;

    int   rise_q[$];
    int   mdir_chg      = -100;
    logic prev_step     = 1'b0, prev_mdir = 1'b0, prev_busy = 1'b0;
    int   busy_len      = 0;
    int   last_busy_len = 0;
    int   busy_fall_cyc = 0;
    int   busy_falls    = 0;

    motor_step_gen #(
        .PERIOD_MAX(PERIOD_MAX), .PERIOD_MIN(PERIOD_MIN), .ACC_STEP(ACC_STEP),
        .PULSE_W(PULSE_W), .DIR_SETUP(DIR_SETUP), .PW(PW)
    ) u_dut (
        .CLK(CLK), .RST(RST), .en(en), .dir(dir),
        .step(step), .mdir(mdir), .busy(busy), .pos(pos)
    );

    // Narrow copy so the signed-position wrap is reachable in a short run.
    motor_step_gen #(
        .PERIOD_MAX(PERIOD_MAX), .PERIOD_MIN(PERIOD_MIN), .ACC_STEP(ACC_STEP),
        .PULSE_W(PULSE_W), .DIR_SETUP(DIR_SETUP), .PW(8)
    ) u_narrow (
        .CLK(CLK), .RST(RST), .en(en), .dir(dir),
        .step(step8), .mdir(mdir8), .busy(busy8), .pos(pos8)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model: one move at a time ----------------
    task automatic model_reset();
        e_step = 1'b0;
        e_mdir = 1'b0;
        e_busy = 1'b0;
        e_pos  = '0;
    endtask

    task automatic run_move();
        int cur;
        cur = PERIOD_MAX;
        for (int k = 0; k < DIR_SETUP; k++) begin
            @(posedge CLK);
            if (RST) begin model_reset(); return; end
        end
        forever begin
            e_step = 1'b1;
            e_pos  = e_mdir ? e_pos + 16'd1 : e_pos - 16'd1;
            for (int k = 1; k < cur; k++) begin
                @(posedge CLK);
                if (RST) begin model_reset(); return; end
                e_step = (k < PULSE_W);
            end
            @(posedge CLK);
            if (RST) begin model_reset(); return; end
            if (en && dir == e_mdir) begin
                cur = (cur - ACC_STEP > PERIOD_MIN) ? cur - ACC_STEP : PERIOD_MIN;
            end else begin
                cur = cur + ACC_STEP;
                if (cur >= PERIOD_MAX) begin
                    e_step = 1'b0;
                    e_busy = 1'b0;
                    return;
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge CLK);
            if (RST) begin
                model_reset();
            end else if (en) begin
                e_mdir = dir;
                e_busy = 1'b1;
                run_move();
            end
        end
    end

    // ---------------- per-cycle compare and waveform monitor ----------------
    always @(negedge CLK) begin
        if (cyc > 0) begin
            check("step", step, e_step);
            check("mdir", mdir, e_mdir);
            check("busy", busy, e_busy);
            check("pos", pos, e_pos);
            check("step_narrow", step8, e_step);
            check("pos_narrow", pos8, e_pos[7:0]);

            if (step && !prev_step) begin
                rise_q.push_back(cyc);
                check("mdir_setup_before_rise", (cyc - mdir_chg) >= DIR_SETUP, 1);
            end
            if (mdir != prev_mdir) begin
                mdir_chg = cyc;
                check("mdir_change_during_step", step, 0);
            end
            if (busy) begin
                busy_len++;
            end else if (prev_busy) begin
                last_busy_len = busy_len;
                busy_len      = 0;
                busy_fall_cyc = cyc;
                busy_falls++;
            end
            prev_step = step;
            prev_mdir = mdir;
            prev_busy = busy;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_rises(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (rise_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        check(name, rise_q.size() >= n, 1);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k;
        k = 0;
        while (busy && k < budget) begin
            tick();
            k++;
        end
        check(name, busy, 0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        int t0, n, b, k;
        int sp[5];
        logic d;
        logic [PW-1:0] p0, pe;

        sp  = '{40, 30, 20, 10, 10};
        RST = 1'b1;
        en  = 1'b0;
        dir = 1'b0;
        tick();
        tick();
        check("rst_step", step, 0);
        check("rst_mdir", mdir, 0);
        check("rst_busy", busy, 0);
        check("rst_pos", pos, 0);

        // Reset then start forward: ramp 40,30,20,10,10.
        RST = 1'b0;
        en  = 1'b1;
        dir = 1'b1;
        tick();
        t0 = cyc;
        check("start_mdir", mdir, 1);
        check("start_busy", busy, 1);
        check("start_step", step, 0);
        wait_rises(6, 400, "ramp_timeout");
        if (rise_q.size() >= 6) begin
            check("first_step_latency", rise_q[0] - t0, DIR_SETUP);
            for (int i = 0; i < 5; i++) check("ramp_spacing", rise_q[i+1] - rise_q[i], sp[i]);
            check("ramp_pos", pos, 6);
        end

        // Stop from cruise: two trailing steps at 20 and 30, then idle.
        en = 1'b0;
        wait_idle(200, "stop_timeout");
        n = rise_q.size();
        check("stop_steps", n, 8);
        if (n >= 3) begin
            check("stop_spacing_a", rise_q[n-2] - rise_q[n-3], 10);
            check("stop_spacing_b", rise_q[n-1] - rise_q[n-2], 20);
            check("stop_tail", busy_fall_cyc - rise_q[n-1], 30);
        end
        check("stop_pos", pos, n);

        // Reversal at cruise: decel 20, 30, one IDLE clock, setup, then reverse steps.
        en  = 1'b1;
        dir = 1'b1;
        wait_cycles(150);
        dir = 1'b0;
        k   = 0;
        while (mdir != 1'b0 && k < 300) begin
            tick();
            k++;
        end
        check("rev_mdir", mdir, 0);
        p0 = pos;
        n  = rise_q.size();
        wait_rises(n + 1, 20, "rev_first_step");
        if (rise_q.size() > n && n >= 2) begin
            check("rev_gap", rise_q[n] - rise_q[n-1], 30 + 1 + DIR_SETUP);
            check("rev_last_fwd_spacing", rise_q[n-1] - rise_q[n-2], 20);
            pe = p0 - 16'd1;
            check("rev_pos", pos, pe);
        end

        // Resume during deceleration: spacings 10, 20, 10 with no visit to IDLE.
        wait_cycles(150);
        en = 1'b0;
        n  = rise_q.size();
        b  = busy_falls;
        wait_rises(n + 1, 20, "resume_decel_step");
        en = 1'b1;
        wait_rises(n + 3, 60, "resume_steps");
        if (rise_q.size() >= n + 3) begin
            check("resume_a", rise_q[n] - rise_q[n-1], 10);
            check("resume_b", rise_q[n+1] - rise_q[n], 20);
            check("resume_c", rise_q[n+2] - rise_q[n+1], 10);
        end
        check("resume_no_idle", busy_falls, b);
        en = 1'b0;
        wait_idle(300, "resume_stop_timeout");

        // Single-step move from a one-clock enable.
        d  = 1'($urandom);
        p0 = pos;
        n  = rise_q.size();
        en  = 1'b1;
        dir = d;
        tick();
        en = 1'b0;
        wait_idle(200, "single_timeout");
        check("single_steps", rise_q.size() - n, 1);
        check("single_busy_len", last_busy_len, DIR_SETUP + PERIOD_MAX);
        pe = d ? p0 + 16'd1 : p0 - 16'd1;
        check("single_pos", pos, pe);

        // Random en/dir activity; the model tracks every cycle.
        for (int s = 0; s < 40; s++) begin
            en  = ($urandom_range(0, 3) != 0);
            dir = 1'($urandom);
            wait_cycles($urandom_range(1, 120));
        end
        en = 1'b0;
        wait_idle(500, "random_drain");

        // Position wrap on the narrow copy, then reset in the middle of a pulse.
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("idle_reset_pos", pos, 0);
        en  = 1'b1;
        dir = 1'b1;
        k   = 0;
        while (pos8 != 8'h7f && k < 3000) begin
            tick();
            k++;
        end
        check("wrap_reach", pos8, 8'h7f);
        n = rise_q.size();
        wait_rises(n + 1, 30, "wrap_step");
        check("wrap_narrow", pos8, 8'h80);
        check("wrap_wide", pos, 16'h0080);
        check("reset_pre_step", step, 1);
        RST = 1'b1;
        tick();
        check("mid_reset_step", step, 0);
        check("mid_reset_pos", pos, 0);
        check("mid_reset_busy", busy, 0);
        check("mid_reset_pos_narrow", pos8, 0);
        RST = 1'b0;
        en  = 1'b0;
        wait_cycles(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
